sub_share_arbiter: RTL and testbench
====================================

Name: sub_share_arbiter

Overview:
- Shares one signed subtract datapath (minuend minus subtrahend) among N_REQ requesters, such as per-channel "measured signal minus noise estimate" paths in the noise-cancelling chain.
- Arbitrates round-robin and computes the difference with saturation or wrap.
- Returns the result with the requester ID through a one-deep registered output stage with a valid/ready handshake.
- Sits between the per-channel sample front-ends and the output DAC/logging stage.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand and result width, two's complement signed.
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester operand-pair valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high.
- req_a  input  N_REQ*WIDTH  minuends, requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  subtrahends, same packing.
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  downstream accepts the result.
- res_data  output  WIDTH  signed result a-b.
- res_id  output  max(1,clog2(N_REQ))  index of the requester that produced res_data.
- res_ovf  output  1  true difference did not fit in WIDTH bits.
- busy  output  1  res_valid OR any req_valid.

Behaviour:
- Reset (rst=0, async): res_valid=0, res_data=0, res_id=0, res_ovf=0, req_ready=0, round-robin pointer=0. Any held result is discarded.
- Output stage states:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
- Accept condition: can_accept = EMPTY, OR (FULL AND res_ready).
- Grant selection:
  - The granted requester is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo N_REQ.
  - req_ready is combinational: one-hot of the granted index when can_accept, else all zero.
  - req_ready never depends on req_valid of other requesters beyond this scan.
- Transfer: a request is consumed on the clock edge where req_valid[i] AND req_ready[i] are both 1.
  - On that edge: res_data, res_id and res_ovf are loaded, res_valid=1, and ptr=(granted+1) mod N_REQ.
- Latency: one cycle, from accepting edge to res_valid visible.
- Throughput: one result per cycle when res_ready is held at 1.
- Hold rule: while FULL and res_ready=0, the outputs stay bit-stable and req_ready stays all zero.
- Simultaneous drain and load (FULL, res_ready=1, grant present): the new result replaces the old one on the same edge; res_valid stays 1.
- Drain with no grant: FULL and res_ready=1 with no req_valid gives res_valid=0 next cycle; res_data and res_id hold their last values.
- Pointer: moves only on an accepted transfer, so idle cycles do not rotate priority.
- Arithmetic:
  - diff = sign-extend(a, WIDTH+1) - sign-extend(b, WIDTH+1).
  - ovf = diff[WIDTH] != diff[WIDTH-1].
  - SATURATE=1 with ovf: result = +max (0x7FFF) when diff is positive, -min (0x8000) when diff is negative.
  - SATURATE=0: result = diff[WIDTH-1:0].
  - res_ovf is reported in both modes.
- Request-side rules:
  - A requester must hold req_valid and its operands stable until accepted. The block does not check this.
  - A requester that drops req_valid before acceptance simply loses its turn; no error is raised.
- Reset mid-transfer: the result is lost and the pointer returns to 0. The first grant after reset release goes to the lowest-index valid requester.

Test Plan:
- Single request: N_REQ=4, req_valid=0001, a=1000, b=300, res_ready=1 -> req_ready=0001 in the same cycle; next cycle res_valid=1, res_data=700, res_id=0, res_ovf=0.
- Round-robin fairness: all four req_valid held high, res_ready=1 -> grants rotate 0,1,2,3,0 on consecutive cycles; res_id follows one cycle later; no requester is served twice before all are served.
- Backpressure: result held (res_id=2) and res_ready=0 for 5 cycles while req_valid=1111 -> outputs stable, req_ready=0000. res_ready rises -> the next grant is to requester 3, in the same cycle as the drain.
- Saturation: SATURATE=1, a=32767, b=-1 -> res_data=32767, res_ovf=1; a=-32768, b=1 -> res_data=-32768, res_ovf=1. SATURATE=0 with the same inputs -> -32768 and 32767, res_ovf=1.
- Boundary without overflow: a=-32768, b=-32768 -> res_data=0, res_ovf=0; a=0, b=-32767 -> res_data=32767, res_ovf=0.
- Async reset: assert rst=0 mid-cycle with FULL -> res_valid=0 immediately with no clock edge needed. After release with req_valid=1010 -> first grant goes to requester 1.

Source files
------------

// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter: round-robin shared signed subtractor feeding a one-deep
// valid/ready result register with optional saturation.
module sub_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int SATURATE = 1
)(
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_REQ-1:0]                            req_valid,
  output logic [N_REQ-1:0]                            req_ready,
  input  logic [N_REQ*WIDTH-1:0]                      req_a,
  input  logic [N_REQ*WIDTH-1:0]                      req_b,
  output logic                                        res_valid,
  input  logic                                        res_ready,
  output logic [WIDTH-1:0]                            res_data,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] res_id,
  output logic                                        res_ovf,
  output logic                                        busy
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [IDW-1:0] ptr, gnt;
  logic found, can_accept, ovf;
  logic [WIDTH-1:0] a, b, result;
  logic [WIDTH:0] diff;
  int idx;
  assign can_accept = !res_valid || res_ready;
  // Scan downward so the last hit written is the first valid at or after ptr.
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        found = 1'b1;
        gnt = IDW'(idx);
      end
    end
  end
  assign req_ready = (rst && found && can_accept) ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt) : '0;
  assign a = req_a[gnt*WIDTH +: WIDTH];
  assign b = req_b[gnt*WIDTH +: WIDTH];
  assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign ovf = diff[WIDTH] ^ diff[WIDTH-1];
  assign result = (SATURATE != 0 && ovf)
                ? (diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                : diff[WIDTH-1:0];
  assign busy = res_valid || (|req_valid);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data <= '0;
      res_id <= '0;
      res_ovf <= 1'b0;
      ptr <= '0;
    end else if (can_accept) begin
      if (found) begin
        res_valid <= 1'b1;
        res_data <= result;
        res_id <= gnt;
        res_ovf <= ovf;
        ptr <= IDW'((int'(gnt) + 1) % N_REQ);
      end else begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb_sub_share_arbiter: scoreboard bench driving a saturating and a wrapping
// instance with identical stimulus against a behavioural arbiter model.
module tb_sub_share_arbiter;
  logic clk = 0, rst = 0, res_ready = 0;
  logic [3:0] req_valid = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [3:0] rdy_s, rdy_w;
  logic val_s, val_w, ovf_s, ovf_w, busy_s, busy_w;
  logic [15:0] dat_s, dat_w;
  logic [1:0] id_s, id_w;
  typedef struct { logic [15:0] ds; logic [15:0] dw; logic [1:0] id; logic ovf; } exp_t;
  exp_t q[$];
  exp_t e;
  int n_checks = 0, n_errors = 0;
  int m_ptr = 0, g, d;
  logic m_full = 0;
  logic [3:0] er;

  sub_share_arbiter #(.N_REQ(4), .WIDTH(16), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_s), .req_a(req_a), .req_b(req_b),
    .res_valid(val_s), .res_ready(res_ready), .res_data(dat_s), .res_id(id_s), .res_ovf(ovf_s), .busy(busy_s));
  sub_share_arbiter #(.N_REQ(4), .WIDTH(16), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w), .req_a(req_a), .req_b(req_b),
    .res_valid(val_w), .res_ready(res_ready), .res_data(dat_w), .res_id(id_w), .res_ovf(ovf_w), .busy(busy_w));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*16 +: 16] = 16'(a);
    req_b[i*16 +: 16] = 16'(b);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      m_ptr = 0;
      m_full = 0;
      q.delete();
    end else begin
      g = -1;
      for (int k = 3; k >= 0; k--) if (req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      er = (g >= 0 && (!m_full || res_ready)) ? 4'(1 << g) : 4'd0;
      check("req_ready_sat", 32'(rdy_s), 32'(er));
      check("req_ready_wrap", 32'(rdy_w), 32'(er));
      check("res_valid", {val_w, val_s}, {m_full, m_full});
      check("busy", {busy_w, busy_s}, {2{m_full | (|req_valid)}});
      if (m_full) begin
        if (q.size() == 0) check("queue_underflow", 32'(q.size()), 32'd1);
        else begin
          check("res_data_sat", 32'(dat_s), 32'(q[0].ds));
          check("res_data_wrap", 32'(dat_w), 32'(q[0].dw));
          check("res_id", {id_w, id_s}, {q[0].id, q[0].id});
          check("res_ovf", {ovf_w, ovf_s}, {q[0].ovf, q[0].ovf});
          if (res_ready) void'(q.pop_front());
        end
      end
      if (!m_full || res_ready) begin
        if (g >= 0) begin
          d = int'($signed(req_a[g*16 +: 16])) - int'($signed(req_b[g*16 +: 16]));
          e.ovf = (d > 32767) || (d < -32768);
          e.ds = e.ovf ? ((d > 0) ? 16'h7FFF : 16'h8000) : 16'(d);
          e.dw = 16'(d);
          e.id = 2'(g);
          q.push_back(e);
          m_ptr = (g + 1) % 4;
          m_full = 1;
        end else m_full = 0;
      end
    end
  end

  initial begin
    step(2);
    check("reset_state", {28'd0, val_s, ovf_s, id_s}, 32'd0);
    check("reset_data", 32'(dat_s), 32'd0);
    check("reset_ready", 32'(rdy_s), 32'd0);
    rst = 1;
    res_ready = 1;
    set_op(0, 1000, 300);
    req_valid = 4'b0001;
    #2;
    check("single_ready", 32'(rdy_s), 32'd1);
    step(1);
    req_valid = 4'b0000;
    check("single_data", 32'(dat_s), 32'd700);
    step(2);
    for (int i = 0; i < 4; i++) set_op(i, 100 * (i + 1), -i);
    req_valid = 4'b1111;
    step(6);
    res_ready = 0;
    step(5);
    res_ready = 1;
    step(3);
    set_op(0, 32767, -1);
    set_op(1, -32768, 1);
    set_op(2, -32768, -32768);
    set_op(3, 0, -32767);
    step(8);
    req_valid = 4'b0000;
    step(3);
    check("drained", 32'(q.size()), 32'd0);
    res_ready = 0;
    req_valid = 4'b0001;
    step(1);
    req_valid = 4'b0000;
    #1 rst = 0;
    #1 check("async_reset", {val_w, val_s}, 2'b00);
    step(1);
    req_valid = 4'b1010;
    res_ready = 1;
    rst = 1;
    #2 check("first_grant_after_reset", 32'(rdy_s), 32'd2);
    step(2);
    for (int n = 0; n < 300; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      res_ready = 1'($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) set_op(i, $urandom_range(0, 65535), $urandom_range(0, 65535));
      step(1);
    end
    req_valid = 4'b0000;
    res_ready = 1;
    step(3);
    check("final_drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
